// File: rtl/instr_decode_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for instr_decode.
// The decoder sits on the slave modport; the driver of the fetch side uses master.
interface instr_decode_if #(
  parameter int CNT_W = 8
);
  logic             flush_i;
  logic             valid_i;
  logic             ready_o;
  logic [31:0]      instr_i;
  logic [31:0]      pc_i;
  logic             valid_o;
  logic             ready_i;
  logic [31:0]      instr_o;
  logic [31:0]      pc_o;
  logic [2:0]       imm_sel_o;
  logic [4:0]       rs1_o;
  logic [4:0]       rs2_o;
  logic [4:0]       rd_o;
  logic             illegal_o;
  logic [CNT_W-1:0] illegal_cnt_o;

  modport slave (
    input  flush_i, valid_i, instr_i, pc_i, ready_i,
    output ready_o, valid_o, instr_o, pc_o, imm_sel_o, rs1_o, rs2_o, rd_o,
           illegal_o, illegal_cnt_o
  );

  modport master (
    output flush_i, valid_i, instr_i, pc_i, ready_i,
    input  ready_o, valid_o, instr_o, pc_o, imm_sel_o, rs1_o, rs2_o, rd_o,
           illegal_o, illegal_cnt_o
  );
endinterface

// File: rtl/instr_decode.sv
// Opcode decoder behind a 2-entry skid FIFO; every output is registered and
// reflects the head entry, with a saturating count of illegal words emitted.
module instr_decode #(
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  instr_decode_if.slave bus
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  sel;
    logic        ill;
  } entry_t;

  entry_t     mem [2];
  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;

  entry_t     in_entry;
  entry_t     head;
  logic       push;
  logic       pop;
  logic [1:0] remain;
  logic [1:0] count_nxt;
  logic       wr_nxt;
  logic       rd_nxt;

  function automatic entry_t decode(input logic [31:0] instr, input logic [31:0] pc);
    entry_t e;
    e.instr = instr;
    e.pc    = pc;
    e.sel   = 3'd0;
    e.ill   = 1'b0;
    // every recognised opcode has [1:0]=11, so the full 7-bit match covers that check
    case (instr[6:0])
      7'b0010011:            e.sel = 3'd1;
      7'b0000011:            e.sel = 3'd2;
      7'b0100011:            e.sel = 3'd3;
      7'b1100011:            e.sel = 3'd4;
      7'b1100111:            e.sel = 3'd5;
      7'b1101111:            e.sel = 3'd6;
      7'b0110111, 7'b0010111: e.sel = 3'd7;
      7'b0110011, 7'b0001111, 7'b1110011: e.sel = 3'd0;
      default:               e.ill = 1'b1;
    endcase
    return e;
  endfunction

  always_comb begin
    in_entry  = decode(bus.instr_i, bus.pc_i);
    push      = bus.valid_i && bus.ready_o && !bus.flush_i;
    pop       = bus.valid_o && bus.ready_i;
    remain    = count - {1'b0, pop};
    count_nxt = bus.flush_i ? 2'd0 : remain + {1'b0, push};
    wr_nxt    = bus.flush_i ? 1'b0 : wr_ptr ^ push;
    rd_nxt    = bus.flush_i ? 1'b0 : rd_ptr ^ pop;
    // with nothing left behind the pop, the incoming word becomes the head directly
    head      = (remain == 2'd0) ? in_entry : mem[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count             <= 2'd0;
      wr_ptr            <= 1'b0;
      rd_ptr            <= 1'b0;
      bus.ready_o       <= 1'b0;
      bus.valid_o       <= 1'b0;
      bus.instr_o       <= '0;
      bus.pc_o          <= '0;
      bus.imm_sel_o     <= '0;
      bus.rs1_o         <= '0;
      bus.rs2_o         <= '0;
      bus.rd_o          <= '0;
      bus.illegal_o     <= 1'b0;
      bus.illegal_cnt_o <= '0;
    end else begin
      count       <= count_nxt;
      wr_ptr      <= wr_nxt;
      rd_ptr      <= rd_nxt;
      bus.ready_o <= (count_nxt != 2'd2);
      bus.valid_o <= (count_nxt != 2'd0);
      if (count_nxt != 2'd0) begin
        bus.instr_o   <= head.instr;
        bus.pc_o      <= head.pc;
        bus.imm_sel_o <= head.sel;
        bus.rs1_o     <= head.instr[19:15];
        bus.rs2_o     <= head.instr[24:20];
        bus.rd_o      <= head.instr[11:7];
        bus.illegal_o <= head.ill;
      end else begin
        bus.imm_sel_o <= 3'd0;
        bus.illegal_o <= 1'b0;
      end
      if (pop && bus.illegal_o && (bus.illegal_cnt_o != {CNT_W{1'b1}}))
        bus.illegal_cnt_o <= bus.illegal_cnt_o + 1'b1;
    end
  end

endmodule
